uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Two-requester transmit scheduler for the NextIO UART. Arbitrates byte
//  pushes from the CPU store path (req0) and the debug/monitor path (req1)
//  into one shared TX FIFO, then sequences the UART transmitter via the
//  send/busy handshake. Replaces per-byte software polling of the CSR send bit.
// PARAMETERS
//  DEPTH         8     FIFO entries; power of 2, >= 2
//  BUSY_TIMEOUT  1024  cycles in SEND waiting for busy=1 before abort; >= 2
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  req0_valid     in   1   requester 0 (CPU) has a byte
//  req0_data      in   8   requester 0 byte
//  req0_ready     out  1   requester 0 byte accepted this cycle if valid
//  req1_valid     in   1   requester 1 (debug) has a byte
//  req1_data      in   8   requester 1 byte
//  req1_ready     out  1   requester 1 byte accepted this cycle if valid
//  uart_tx_busy   in   1   transmitter busy, from UART TX core
//  uart_send      out  1   send strobe/level to UART TX core
//  uart_data      out  8   byte presented to UART TX core
//  fifo_count     out  $clog2(DEPTH)+1  entries held
//  fifo_full      out  1   fifo_count == DEPTH
//  fifo_empty     out  1   fifo_count == 0
//  idle           out  1   FIFO empty and FSM in IDLE
//  err_clr        in   1   clears err_timeout
//  err_timeout    out  1   sticky: a byte was dropped on busy timeout
// BEHAVIOUR
//  Reset (async, immediate): pointers/count 0, FSM IDLE, uart_send 0,
//   uart_data 0, err_timeout 0, timeout counter 0, RR last-grant = req1
//   (so req0 has priority first). fifo_empty=1, idle=1, readys 0 while rst.
//  Reset mid-transfer: in-flight and queued bytes discarded, no send issued.
//  Arbiter (combinational grant, registered priority):
//   - ready only when !fifo_full; full uses registered count, so a pop in
//     the same cycle does NOT free a slot for a push (no push when full).
//   - one valid -> that requester granted. Both valid -> requester not
//     granted last time wins; last-grant updates only on accepted push.
//   - readyN = grantN & !fifo_full; accept = validN & readyN; at most one
//     push per cycle. ready may be high while valid low (no accept).
//  FIFO: write at wr_ptr, read at rd_ptr, pointers wrap modulo DEPTH.
//   Simultaneous push and pop: count unchanged, both pointers advance.
//  TX FSM:
//   IDLE : if !fifo_empty -> pop head into uart_data, timer=0, -> SEND.
//   SEND : uart_send=1. busy=1 -> uart_send=0, -> WAIT_DONE.
//          else timer++; timer==BUSY_TIMEOUT-1 -> uart_send=0,
//          err_timeout=1, byte dropped, -> IDLE.
//   WAIT_DONE: busy=0 -> IDLE (next pop may occur that same edge+1).
//  uart_send is registered: high exactly from edge entering SEND to edge
//   leaving it. uart_data holds last popped byte until next pop.
//  Latency: byte accepted at edge E0 into empty FIFO -> popped at E1,
//   uart_send=1 after E1. Busy high pulse seen at E -> send low after E.
//  busy already 1 on entry to SEND counts immediately (next edge).
//  err_timeout: set wins over err_clr in same cycle; else err_clr clears.
//  Width: fifo_count holds 0..DEPTH inclusive; no overflow/underflow ever
//   (push gated by full, pop gated by empty).
// TESTING
//  1 reset then req0 0x41 once; busy rises 3 cyc after send, 10 cyc high
//    -> uart_data=0x41, send high 3 cyc, idle=1 after busy falls, count 0.
//  2 req0,req1 both valid continuously with 0xA0../0xB0.., busy model on
//    -> bytes interleave A0,B0,A1,B1...; first grant req0; no byte lost.
//  3 hold busy low, push DEPTH+2 bytes from req1 -> fifo_full after
//    DEPTH accepts minus pops, req1_ready=0 while full, order preserved.
//  4 never assert busy -> send high BUSY_TIMEOUT cyc, err_timeout=1, next
//    byte then sent; err_clr pulse -> err_timeout=0.
//  5 assert rst while in WAIT_DONE with 3 queued -> send=0, count=0,
//    idle=1 immediately (async), no send after release with busy=0.
//  6 full FIFO, pop and req0 valid same cycle -> no accept that cycle,
//    count=DEPTH-1, accept next cycle.

Source files
------------

// File: rtl/uart_tx_sched.sv
`timescale 1ns/1ps
// Two-requester round-robin push arbiter feeding a shared TX FIFO, plus the
// send/busy sequencer that drains that FIFO into the UART transmitter core.
module uart_tx_sched #(
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int DATA_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [DATA_W-1:0]      req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [DATA_W-1:0]      req1_data,
  output logic                   req1_ready,
  input  logic                   uart_tx_busy,
  output logic                   uart_send,
  output logic [DATA_W-1:0]      uart_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   idle,
  input  logic                   err_clr,
  output logic                   err_timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(BUSY_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [TMR_W-1:0]  timer;

  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              acc0;
  logic              acc1;
  logic              push;
  logic [DATA_W-1:0] push_data;

  logic              pop;
  logic              timeout_hit;
  logic              timer_run;

  assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign idle       = fifo_empty && (state == S_IDLE);

  // Arbiter: full comes from the registered count, so a same-cycle pop never
  // opens a slot for a push.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = grant0 && !fifo_full && !rst;
    req1_ready = grant1 && !fifo_full && !rst;
    acc0       = req0_valid && req0_ready;
    acc1       = req1_valid && req1_ready;
    push       = acc0 || acc1;
    push_data  = acc1 ? req1_data : req0_data;
  end

  // last_grant = 1 means req1 won most recently, which gives req0 first turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (acc0) begin
      last_grant <= 1'b0;
    end else if (acc1) begin
      last_grant <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // uart_send is registered from the next state so it tracks SEND exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      uart_send <= 1'b0;
    end else begin
      state     <= state_nxt;
      uart_send <= (state_nxt == S_SEND);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (uart_tx_busy) begin
          state_nxt = S_WAIT_DONE;
        end else if (timer == TMR_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    timeout_hit = 1'b0;
    timer_run   = 1'b0;
    case (state)
      S_IDLE: begin
        pop = !fifo_empty;
      end
      S_SEND: begin
        timeout_hit = !uart_tx_busy && (timer == TMR_LAST);
        timer_run   = !uart_tx_busy && (timer != TMR_LAST);
      end
      default: begin
        pop = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (pop) begin
      timer <= '0;
    end else if (timer_run) begin
      timer <= timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_data <= '0;
    end else if (pop) begin
      uart_data <= mem[rd_ptr];
    end
  end

  // A timeout in the same cycle as err_clr must still leave the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout <= 1'b1;
    end else if (err_clr) begin
      err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
// Bench for uart_tx_sched: behavioural UART busy responder, transmit monitor
// and a queue-based scoreboard of accepted bytes.
module tb_uart_tx_sched;

  localparam int DEPTH = 8;
  localparam int BT    = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       uart_tx_busy;
  logic       uart_send;
  logic [7:0] uart_data;
  logic [3:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       idle;
  logic       err_clr = 1'b0;
  logic       err_timeout;

  logic busy_man = 1'b0;
  logic busy_bm  = 1'b0;
  bit   bm_en    = 1'b0;
  int   bm_d     = 1;
  int   bm_h     = 1;
  int   bm_phase = 0;
  int   bm_cnt   = 0;

  logic [7:0] tx_q [$];
  int   send_rises = 0;
  int   send_len   = 0;
  int   last_len   = 0;
  logic send_prev  = 1'b0;

  int checks   = 0;
  int failures = 0;

  assign uart_tx_busy = bm_en ? busy_bm : busy_man;

  uart_tx_sched #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .uart_tx_busy(uart_tx_busy), .uart_send(uart_send), .uart_data(uart_data),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .idle(idle), .err_clr(err_clr), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Monitor and UART responder: busy rises bm_d cycles after send is first
  // seen and stays high for bm_h cycles.
  always @(negedge clk) begin
    if (uart_send && !send_prev) begin
      tx_q.push_back(uart_data);
      send_rises = send_rises + 1;
    end
    if (uart_send) begin
      send_len = send_len + 1;
    end else if (send_prev) begin
      last_len = send_len;
      send_len = 0;
    end
    send_prev = uart_send;
    if (!bm_en) begin
      bm_phase = 0;
      busy_bm  = 1'b0;
    end else begin
      case (bm_phase)
        0: if (uart_send) begin
          bm_cnt = 0;
          if (bm_d == 0) begin
            busy_bm = 1'b1;
            bm_phase = 2;
          end else begin
            bm_phase = 1;
          end
        end
        1: begin
          bm_cnt = bm_cnt + 1;
          if (bm_cnt == bm_d) begin
            busy_bm = 1'b1;
            bm_cnt = 0;
            bm_phase = 2;
          end
        end
        default: begin
          bm_cnt = bm_cnt + 1;
          if (bm_cnt == bm_h) begin
            busy_bm = 1'b0;
            bm_phase = 0;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bm_en = 1'b0;
    busy_man = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    err_clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int bound, input string name);
    int w;
    w = 0;
    while (!idle && w < bound) begin
      tick();
      w++;
    end
    checks++;
    if (idle !== 1'b1) begin
      failures++;
      $display("FAIL %s_idle: idle=%b after %0d cycles, required 1", name, idle, bound);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL rst_ready: got %b required 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({fifo_empty, idle, fifo_full} !== 3'b110) begin
      failures++;
      $display("FAIL rst_flags: empty/idle/full got %b required 110", {fifo_empty, idle, fifo_full});
    end
    checks++;
    if ({uart_send, uart_data, fifo_count, err_timeout} !== 14'h0) begin
      failures++;
      $display("FAIL rst_outs: send=%b data=%h count=%0d err=%b required all 0",
               uart_send, uart_data, fifo_count, err_timeout);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL rst_first_grant: got %b required 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int base, w;
    logic saw_busy;
    apply_reset();
    bm_d = 2;
    bm_h = 10;
    bm_en = 1'b1;
    base = tx_q.size();
    req0_valid = 1'b1;
    req0_data = 8'h41;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready: got %b required 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({uart_send, fifo_count} !== {1'b0, 4'd1}) begin
      failures++;
      $display("FAIL single_e0: send=%b count=%0d required 0/1", uart_send, fifo_count);
    end
    tick();
    checks++;
    if ({uart_send, uart_data, fifo_count} !== {1'b1, 8'h41, 4'd0}) begin
      failures++;
      $display("FAIL single_e1: send=%b data=%h count=%0d required 1/41/0", uart_send, uart_data, fifo_count);
    end
    saw_busy = 1'b0;
    w = 0;
    while (!(saw_busy && !uart_tx_busy) && w < 60) begin
      if (uart_tx_busy) saw_busy = 1'b1;
      tick();
      w++;
    end
    checks++;
    if ({idle, fifo_count} !== {1'b1, 4'd0}) begin
      failures++;
      $display("FAIL single_done: idle=%b count=%0d required 1/0", idle, fifo_count);
    end
    checks++;
    if (last_len != 3) begin
      failures++;
      $display("FAIL single_send_len: got %0d cycles required 3", last_len);
    end
    checks++;
    if (tx_q.size() != base + 1 || tx_q[tx_q.size()-1] !== 8'h41) begin
      failures++;
      $display("FAIL single_tx: %0d bytes sent, required 1 byte 41", tx_q.size() - base);
    end
  endtask

  task automatic test_interleave();
    int i0, i1, base, cyc, k;
    logic a0, a1, got_first;
    logic [7:0] exp_b;
    apply_reset();
    bm_d = $urandom_range(0, 3);
    bm_h = $urandom_range(1, 4);
    bm_en = 1'b1;
    base = tx_q.size();
    i0 = 0; i1 = 0; cyc = 0; got_first = 1'b0;
    while ((i0 < 6 || i1 < 6) && cyc < 500) begin
      req0_valid = (i0 < 6);
      req0_data  = 8'hA0 + 8'(i0);
      req1_valid = (i1 < 6);
      req1_data  = 8'hB0 + 8'(i1);
      #1;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0 && a1) begin
        checks++;
        failures++;
        $display("FAIL ilv_double_accept: both readys high at cycle %0d", cyc);
      end
      if (!got_first && (a0 || a1)) begin
        got_first = 1'b1;
        checks++;
        if (a0 !== 1'b1) begin
          failures++;
          $display("FAIL ilv_first_grant: got req1 required req0");
        end
      end
      tick();
      if (a0) i0++;
      if (a1) i1++;
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (i0 != 6 || i1 != 6) begin
      failures++;
      $display("FAIL ilv_accepts: got %0d/%0d required 6/6", i0, i1);
    end
    wait_idle(500, "ilv");
    checks++;
    if (tx_q.size() != base + 12) begin
      failures++;
      $display("FAIL ilv_count: got %0d bytes required 12", tx_q.size() - base);
    end
    for (k = 0; k < 12 && base + k < tx_q.size(); k++) begin
      exp_b = (k % 2 == 0) ? 8'hA0 + 8'(k / 2) : 8'hB0 + 8'(k / 2);
      checks++;
      if (tx_q[base+k] !== exp_b) begin
        failures++;
        $display("FAIL ilv_order[%0d]: got %h required %h", k, tx_q[base+k], exp_b);
      end
    end
  endtask

  task automatic test_full();
    int i, base, c, k;
    logic acc;
    apply_reset();
    base = tx_q.size();
    i = 0;
    for (c = 0; c < 15; c++) begin
      req1_valid = (i < DEPTH + 2);
      req1_data  = 8'hC0 + 8'(i);
      #1;
      acc = req1_valid && req1_ready;
      checks++;
      if (fifo_full && req1_ready) begin
        failures++;
        $display("FAIL full_ready: ready=1 while full at cycle %0d", c);
      end
      tick();
      if (acc) i++;
    end
    #1;
    checks++;
    if (i != DEPTH + 1 || fifo_count != DEPTH || fifo_full !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_state: accepts=%0d count=%0d full=%b ready=%b required %0d/%0d/1/0",
               i, fifo_count, fifo_full, req1_ready, DEPTH + 1, DEPTH);
    end
    bm_d = 1;
    bm_h = 2;
    bm_en = 1'b1;
    c = 0;
    while (i < DEPTH + 2 && c < 200) begin
      req1_valid = 1'b1;
      req1_data  = 8'hC0 + 8'(i);
      #1;
      acc = req1_ready;
      tick();
      if (acc) i++;
      c++;
    end
    req1_valid = 1'b0;
    wait_idle(300, "full");
    checks++;
    if (tx_q.size() != base + DEPTH + 2) begin
      failures++;
      $display("FAIL full_count: got %0d bytes required %0d", tx_q.size() - base, DEPTH + 2);
    end
    for (k = 0; k < DEPTH + 2 && base + k < tx_q.size(); k++) begin
      checks++;
      if (tx_q[base+k] !== 8'hC0 + 8'(k)) begin
        failures++;
        $display("FAIL full_order[%0d]: got %h required %h", k, tx_q[base+k], 8'hC0 + 8'(k));
      end
    end
  endtask

  task automatic test_timeout();
    int base, w;
    logic seen, fell;
    apply_reset();
    base = tx_q.size();
    req0_valid = 1'b1;
    req0_data = 8'h11;
    tick();
    req0_data = 8'h22;
    tick();
    req0_valid = 1'b0;
    seen = 1'b0; fell = 1'b0; w = 0;
    while (!fell && w < BT + 20) begin
      if (uart_send) seen = 1'b1;
      else if (seen) fell = 1'b1;
      if (!fell) tick();
      w++;
    end
    checks++;
    if (err_timeout !== 1'b1 || !fell) begin
      failures++;
      $display("FAIL to_err: err=%b fell=%b required 1/1", err_timeout, fell);
    end
    tick();
    checks++;
    if (last_len != BT) begin
      failures++;
      $display("FAIL to_send_len: got %0d cycles required %0d", last_len, BT);
    end
    bm_d = 0;
    bm_h = 3;
    bm_en = 1'b1;
    wait_idle(100, "to");
    checks++;
    if (tx_q.size() != base + 2 || tx_q[base] !== 8'h11 || tx_q[base+1] !== 8'h22 || err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL to_next: bytes=%0d err=%b required 2 bytes 11,22 and err 1", tx_q.size() - base, err_timeout);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_clr: err=%b required 0", err_timeout);
    end
    bm_en = 1'b0;
    req0_valid = 1'b1;
    req0_data = 8'h33;
    tick();
    req0_valid = 1'b0;
    err_clr = 1'b1;
    seen = 1'b0; fell = 1'b0; w = 0;
    while (!fell && w < BT + 20) begin
      if (uart_send) seen = 1'b1;
      else if (seen) fell = 1'b1;
      if (!fell) tick();
      w++;
    end
    checks++;
    if (err_timeout !== 1'b1 || !fell) begin
      failures++;
      $display("FAIL to_set_wins: err=%b fell=%b required 1/1", err_timeout, fell);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_clr_after: err=%b required 0", err_timeout);
    end
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k, w, rises0;
    apply_reset();
    bm_d = 1;
    bm_h = 100;
    bm_en = 1'b1;
    k = 0; w = 0;
    while (k < 4 && w < 20) begin
      req0_valid = 1'b1;
      req0_data = 8'h51 + 8'(k);
      #1;
      if (req0_ready) k++;
      tick();
      w++;
    end
    req0_valid = 1'b0;
    w = 0;
    while (!(!uart_send && uart_tx_busy) && w < 50) begin
      tick();
      w++;
    end
    checks++;
    if (fifo_count != 3 || uart_tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup: count=%0d busy=%b required 3/1", fifo_count, uart_tx_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({uart_send, fifo_count, idle, fifo_empty} !== {1'b0, 4'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL mid_async: send=%b count=%0d idle=%b empty=%b required 0/0/1/1",
               uart_send, fifo_count, idle, fifo_empty);
    end
    bm_en = 1'b0;
    rises0 = send_rises;
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    checks++;
    if (send_rises != rises0 || uart_send !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL mid_after: extra sends=%0d send=%b idle=%b required 0/0/1",
               send_rises - rises0, uart_send, idle);
    end
  endtask

  task automatic test_full_pop();
    int k, w;
    logic acc;
    apply_reset();
    req0_valid = 1'b1;
    req0_data = 8'h60;
    tick();
    req0_valid = 1'b0;
    tick();
    busy_man = 1'b1;
    tick();
    checks++;
    if (uart_send !== 1'b0 || uart_data !== 8'h60) begin
      failures++;
      $display("FAIL fp_wait: send=%b data=%h required 0/60", uart_send, uart_data);
    end
    k = 0; w = 0;
    while (k < DEPTH && w < 40) begin
      req0_valid = 1'b1;
      req0_data = 8'h61 + 8'(k);
      #1;
      acc = req0_ready;
      tick();
      if (acc) k++;
      w++;
    end
    req0_data = 8'h7F;
    #1;
    checks++;
    if (fifo_count != DEPTH || fifo_full !== 1'b1 || req0_ready !== 1'b0) begin
      failures++;
      $display("FAIL fp_full: count=%0d full=%b ready=%b required %0d/1/0", fifo_count, fifo_full, req0_ready, DEPTH);
    end
    busy_man = 1'b0;
    tick();
    checks++;
    if (fifo_count != DEPTH) begin
      failures++;
      $display("FAIL fp_edge_a: count=%0d required %0d", fifo_count, DEPTH);
    end
    tick();
    checks++;
    if (fifo_count != DEPTH - 1 || uart_send !== 1'b1 || uart_data !== 8'h61) begin
      failures++;
      $display("FAIL fp_pop_no_push: count=%0d send=%b data=%h required %0d/1/61",
               fifo_count, uart_send, uart_data, DEPTH - 1);
    end
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL fp_ready_next: got %b required 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if (fifo_count != DEPTH) begin
      failures++;
      $display("FAIL fp_accept_next: count=%0d required %0d", fifo_count, DEPTH);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q [$];
    int base, mcount, acc_prev, k;
    logic last_g, prev_send, v0, v1, full, e0, e1, a0, a1;
    apply_reset();
    bm_d = $urandom_range(0, 2);
    bm_h = $urandom_range(1, 3);
    bm_en = 1'b1;
    base = tx_q.size();
    mcount = 0; acc_prev = 0; last_g = 1'b1; prev_send = uart_send;
    for (int c = 0; c < 300; c++) begin
      mcount = mcount + acc_prev;
      if (uart_send && !prev_send) mcount = mcount - 1;
      prev_send = uart_send;
      checks++;
      if (fifo_count != mcount || fifo_full !== (mcount == DEPTH) || fifo_empty !== (mcount == 0)) begin
        failures++;
        $display("FAIL rnd_count: cycle %0d count=%0d full=%b empty=%b required count %0d",
                 c, fifo_count, fifo_full, fifo_empty, mcount);
      end
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      req0_valid = v0;
      req1_valid = v1;
      req0_data = 8'($urandom);
      req1_data = 8'($urandom);
      #1;
      full = (mcount == DEPTH);
      e0 = v0 && !full && (!v1 || last_g);
      e1 = v1 && !full && (!v0 || !last_g);
      a0 = v0 && req0_ready;
      a1 = v1 && req1_ready;
      checks++;
      if ({a0, a1} !== {e0, e1}) begin
        failures++;
        $display("FAIL rnd_grant: cycle %0d accepts=%b%b required %b%b", c, a0, a1, e0, e1);
      end
      if (e0) begin
        exp_q.push_back(req0_data);
        last_g = 1'b0;
      end
      if (e1) begin
        exp_q.push_back(req1_data);
        last_g = 1'b1;
      end
      acc_prev = (e0 || e1) ? 1 : 0;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle(600, "rnd");
    checks++;
    if (tx_q.size() != base + exp_q.size() || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL rnd_total: sent %0d required %0d err=%b", tx_q.size() - base, exp_q.size(), err_timeout);
    end
    for (k = 0; k < exp_q.size() && base + k < tx_q.size(); k++) begin
      checks++;
      if (tx_q[base+k] !== exp_q[k]) begin
        failures++;
        $display("FAIL rnd_order[%0d]: got %h required %h", k, tx_q[base+k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_interleave();
    test_full();
    test_timeout();
    test_reset_mid();
    test_full_pop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
